// File: rtl/score_pkg.sv
`default_nettype none
// ============================================================================
// Module      : score_pkg
// Description : Shared types and constants for the two-player score controller.
// Revision    : 1.0 - initial release
// ============================================================================
package score_pkg;

    typedef enum logic [0:0] {
        ST_PLAY = 1'b0,
        ST_WIN  = 1'b1
    } state_t;

    localparam logic [1:0] C_WINNER_NONE = 2'b00;
    localparam logic [1:0] C_WINNER_P1   = 2'b01;
    localparam logic [1:0] C_WINNER_P2   = 2'b10;

    localparam int DEFAULT_WIN_SCORE = 7;

endpackage : score_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin arbiter; i_ptr = 0 favours requester 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import score_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = i_ptr ? 2'b10 : 2'b01;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/score_controller.sv
`default_nettype none
// ============================================================================
// Module      : score_controller
// Description : Two-player point arbiter and scorekeeper with PLAY/WIN FSM.
//               Define SCORE_BLINK_EN to blink the winner's digit in WIN.
// Revision    : 1.0 - initial release
// ============================================================================
module score_controller
    import score_pkg::*;
#(
    parameter int WIN_SCORE = DEFAULT_WIN_SCORE,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p1_req,
    input  logic       p2_req,
    input  logic       clear,
    output logic [3:0] p1_digit,
    output logic [3:0] p2_digit,
    output logic       p1_blank,
    output logic       p2_blank,
    output logic [1:0] grant,
    output logic [1:0] winner,
    output logic       game_over
);

    localparam logic [3:0] C_WIN_SCORE = 4'(WIN_SCORE);

    if (WIN_SCORE < 1 || WIN_SCORE > 15 || BLINK_DIV < 1) begin : g_param_check
        $error("score_controller: WIN_SCORE must be 1..15 and BLINK_DIV >= 1");
    end

    state_t     state_q,  state_d;
    logic [1:0] pend_q,   pend_d;
    logic [3:0] score1_q, score1_d;
    logic [3:0] score2_q, score2_d;
    logic [1:0] grant_q,  grant_d;
    logic [1:0] winner_q, winner_d;
    logic       ptr_q,    ptr_d;
    logic [1:0] w_arb_gnt;
    logic [3:0] w_score1_inc;
    logic [3:0] w_score2_inc;

    rr_arbiter2 u_arb (
        .i_req (pend_q),
        .i_ptr (ptr_q),
        .o_gnt (w_arb_gnt)
    );

    assign w_score1_inc = score1_q + 4'd1;
    assign w_score2_inc = score2_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        score1_d = score1_q;
        score2_d = score2_q;
        grant_d  = 2'b00;
        winner_d = winner_q;
        ptr_d    = ptr_q;

        if (clear) begin
            state_d  = ST_PLAY;
            pend_d   = 2'b00;
            score1_d = 4'd0;
            score2_d = 4'd0;
            winner_d = C_WINNER_NONE;
        end else if (state_q == ST_PLAY) begin
            // A set flag is either being granted now or holds; either way a new pulse is dropped.
            pend_d  = (pend_q & ~w_arb_gnt) | ({p2_req, p1_req} & ~pend_q);
            grant_d = w_arb_gnt;
            if (w_arb_gnt[0]) begin
                score1_d = w_score1_inc;
                ptr_d    = 1'b1;
                if (w_score1_inc == C_WIN_SCORE) begin
                    state_d  = ST_WIN;
                    winner_d = C_WINNER_P1;
                    pend_d   = 2'b00;
                end
            end else if (w_arb_gnt[1]) begin
                score2_d = w_score2_inc;
                ptr_d    = 1'b0;
                if (w_score2_inc == C_WIN_SCORE) begin
                    state_d  = ST_WIN;
                    winner_d = C_WINNER_P2;
                    pend_d   = 2'b00;
                end
            end
        end else begin
            pend_d = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_PLAY;
            pend_q   <= 2'b00;
            score1_q <= 4'd0;
            score2_q <= 4'd0;
            grant_q  <= 2'b00;
            winner_q <= C_WINNER_NONE;
            ptr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            grant_q  <= grant_d;
            winner_q <= winner_d;
            ptr_q    <= ptr_d;
        end
    end

    assign p1_digit  = score1_q;
    assign p2_digit  = score2_q;
    assign grant     = grant_q;
    assign winner    = winner_q;
    assign game_over = (state_q == ST_WIN);

`ifdef SCORE_BLINK_EN
    localparam int C_BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [C_BLINK_W-1:0] C_BLINK_LAST = C_BLINK_W'(BLINK_DIV - 1);

    logic [C_BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [1:0]           blank_q,     blank_d;

    // blank bits line up with the one-hot winner code, so entry and toggle reuse it directly.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blank_d     = blank_q;
        if (clear) begin
            blink_cnt_d = '0;
            blank_d     = 2'b00;
        end else if (state_q == ST_PLAY) begin
            blink_cnt_d = '0;
            blank_d     = (state_d == ST_WIN) ? winner_d : 2'b00;
        end else if (blink_cnt_q == C_BLINK_LAST) begin
            blink_cnt_d = '0;
            blank_d     = blank_q ^ winner_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_q <= '0;
            blank_q     <= 2'b00;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blank_q     <= blank_d;
        end
    end

    assign p1_blank = blank_q[0];
    assign p2_blank = blank_q[1];
`else
    assign p1_blank = 1'b0;
    assign p2_blank = 1'b0;
`endif

endmodule : score_controller
`default_nettype wire

// File: tb/tb_score_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_controller
// Description : Directed self-checking bench for score_controller
//               (WIN_SCORE = 7, BLINK_DIV = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_controller;

`ifdef SCORE_BLINK_EN
    localparam logic C_BLINK = 1'b1;
`else
    localparam logic C_BLINK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       p1_req;
    logic       p2_req;
    logic       clear;
    logic [3:0] p1_digit;
    logic [3:0] p2_digit;
    logic       p1_blank;
    logic       p2_blank;
    logic [1:0] grant;
    logic [1:0] winner;
    logic       game_over;

    int n_checks = 0;
    int n_errors = 0;

    score_controller #(
        .WIN_SCORE (7),
        .BLINK_DIV (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .p1_req    (p1_req),
        .p2_req    (p2_req),
        .clear     (clear),
        .p1_digit  (p1_digit),
        .p2_digit  (p2_digit),
        .p1_blank  (p1_blank),
        .p2_blank  (p2_blank),
        .grant     (grant),
        .winner    (winner),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".p1_digit"},  32'(p1_digit),  32'd0);
        check({tag, ".p2_digit"},  32'(p2_digit),  32'd0);
        check({tag, ".grant"},     32'(grant),     32'd0);
        check({tag, ".winner"},    32'(winner),    32'd0);
        check({tag, ".game_over"}, 32'(game_over), 32'd0);
        check({tag, ".p1_blank"},  32'(p1_blank),  32'd0);
        check({tag, ".p2_blank"},  32'(p2_blank),  32'd0);
    endtask

    initial begin
        reset  = 1'b1;
        p1_req = 1'b0;
        p2_req = 1'b0;
        clear  = 1'b0;
        #3;
        check_idle("por");
        tick();
        tick();
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Single uncontended P1 point: 2-edge latency, one-cycle grant
        p1_req = 1'b1;
        tick();
        p1_req = 1'b0;
        check("p1_lat_e1.digit", 32'(p1_digit), 32'd0);
        check("p1_lat_e1.grant", 32'(grant),    32'd0);
        tick();
        check("p1_lat_e2.digit", 32'(p1_digit), 32'd1);
        check("p1_lat_e2.grant", 32'(grant),    32'd1);
        tick();
        check("p1_lat_e3.grant", 32'(grant),    32'd0);
        check("p1_lat_e3.digit", 32'(p1_digit), 32'd1);

        // Request in flight, then asynchronous reset between edges
        p2_req = 1'b1;
        tick();
        p2_req = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_idle("async_rst");
        @(negedge clk);
        reset = 1'b0;
        tick();
        tick();
        check("rst_drop.p2_digit", 32'(p2_digit), 32'd0);
        check("rst_drop.grant",    32'(grant),    32'd0);

        // Simultaneous pair after reset: P1 first, P2 one edge later
        p1_req = 1'b1;
        p2_req = 1'b1;
        tick();
        p1_req = 1'b0;
        p2_req = 1'b0;
        check("pair1_e1.grant", 32'(grant), 32'd0);
        tick();
        check("pair1_e2.grant", 32'(grant),    32'd1);
        check("pair1_e2.p1",    32'(p1_digit), 32'd1);
        check("pair1_e2.p2",    32'(p2_digit), 32'd0);
        tick();
        check("pair1_e3.grant", 32'(grant),    32'd2);
        check("pair1_e3.p2",    32'(p2_digit), 32'd1);
        tick();
        check("pair1_e4.grant", 32'(grant), 32'd0);

        // Second pair: P2 was last served, so P1 leads again
        p1_req = 1'b1;
        p2_req = 1'b1;
        tick();
        p1_req = 1'b0;
        p2_req = 1'b0;
        tick();
        check("pair2_e2.grant", 32'(grant),    32'd1);
        check("pair2_e2.p1",    32'(p1_digit), 32'd2);
        tick();
        check("pair2_e3.grant", 32'(grant),    32'd2);
        check("pair2_e3.p2",    32'(p2_digit), 32'd2);

        // Back-to-back P1 pulses: the second hits a set flag and is dropped
        p1_req = 1'b1;
        tick();
        tick();
        p1_req = 1'b0;
        check("dup_e2.grant", 32'(grant),    32'd1);
        check("dup_e2.p1",    32'(p1_digit), 32'd3);
        tick();
        check("dup_e3.grant", 32'(grant),    32'd0);
        tick();
        check("dup_e4.p1",    32'(p1_digit), 32'd3);

        // P2 climbs from 2 to 7 and wins
        for (int i = 0; i < 5; i++) begin
            p2_req = 1'b1;
            tick();
            p2_req = 1'b0;
            tick();
            check("climb.p2", 32'(p2_digit), 32'(3 + i));
            check("climb.game_over", 32'(game_over), (i == 4) ? 32'd1 : 32'd0);
        end
        check("win.grant",    32'(grant),    32'd2);
        check("win.winner",   32'(winner),   32'd2);
        check("win.p2_blank", 32'(p2_blank), 32'(C_BLINK));
        check("win.p1_blank", 32'(p1_blank), 32'd0);

        // Requests in WIN are ignored; blink half-period is 4 edges
        p1_req = 1'b1;
        tick();
        p1_req = 1'b0;
        tick();
        tick();
        check("win_e3.p1",       32'(p1_digit), 32'd3);
        check("win_e3.p2",       32'(p2_digit), 32'd7);
        check("win_e3.grant",    32'(grant),    32'd0);
        check("win_e3.winner",   32'(winner),   32'd2);
        check("win_e3.p2_blank", 32'(p2_blank), 32'(C_BLINK));
        tick();
        check("win_e4.p2_blank", 32'(p2_blank), 32'd0);
        tick();
        tick();
        tick();
        check("win_e7.p2_blank", 32'(p2_blank), 32'd0);
        tick();
        check("win_e8.p2_blank", 32'(p2_blank), 32'(C_BLINK));
        check("win_e8.p1_blank", 32'(p1_blank), 32'd0);

        // Clear beats a same-edge request
        clear  = 1'b1;
        p2_req = 1'b1;
        tick();
        clear  = 1'b0;
        p2_req = 1'b0;
        check_idle("clear");
        tick();
        tick();
        check("clear_drop.p2",    32'(p2_digit), 32'd0);
        check("clear_drop.grant", 32'(grant),    32'd0);

        // Pointer survives clear: P2 was last served, so P1 leads
        p1_req = 1'b1;
        p2_req = 1'b1;
        tick();
        p1_req = 1'b0;
        p2_req = 1'b0;
        tick();
        check("post_clear_e2.grant", 32'(grant), 32'd1);
        tick();
        check("post_clear_e3.grant", 32'(grant),    32'd2);
        check("post_clear_e3.p1",    32'(p1_digit), 32'd1);
        check("post_clear_e3.p2",    32'(p2_digit), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_score_controller
`default_nettype wire
